// File: rtl/stp_fsm_pkg.sv
// Shared definitions for the store-polynomial (STP) writer and the evaluate
// (EVP) reader: state encoding, status codes, slot geometry and a log2 helper.
package stp_fsm_pkg;

    // State encoding, kept as plain constants so EVP can decode the same values.
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_START    = 3'd1;
    localparam logic [2:0] ST_CHECK_N  = 3'd2;
    localparam logic [2:0] ST_RD_COEFF = 3'd3;
    localparam logic [2:0] ST_WR_COEFF = 3'd4;
    localparam logic [2:0] ST_WR_N     = 3'd5;
    localparam logic [2:0] ST_ERROR    = 3'd6;
    localparam logic [2:0] ST_END      = 3'd7;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        START    = ST_START,
        CHECK_N  = ST_CHECK_N,
        RD_COEFF = ST_RD_COEFF,
        WR_COEFF = ST_WR_COEFF,
        WR_N     = ST_WR_N,
        ERROR    = ST_ERROR,
        END      = ST_END
    } stp_state_t;

    // Result codes reported on status.
    localparam logic [31:0] STATUS_OK    = 32'd0;
    localparam logic [31:0] STATUS_BAD_N = 32'd2;
    localparam logic [31:0] STATUS_NONE  = 32'hFFFF_FFFF;

    // Slot geometry: one slot holds coefficients 0..MAX_DEGREE.
    localparam int          SLOT_SIZE  = 11;
    localparam int          MAX_DEGREE = SLOT_SIZE - 1;

    // Degree value that marks a slot as not holding a valid polynomial.
    localparam logic [4:0]  N_INVALID  = 5'b11111;

    // Ceiling log2, used for pointer widths (log2(1024) = 10).
    function automatic int log2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/stp_fsm.sv
// Store-polynomial writer: copies N+1 coefficients from the input data buffer
// into a slot of the S RAM and commits the degree into the N RAM. The slot is
// invalidated (N=31) before any coefficient write and only committed after
// the last one, so a reader never sees a half-written slot as valid.
module stp_fsm
    import stp_fsm_pkg::*;
#(
    parameter int buffer_size = 1024,
    parameter int slot_size   = SLOT_SIZE,
    parameter int max_degree  = MAX_DEGREE,
    localparam int AW         = log2(buffer_size)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_stp,
    input  logic [2:0]    A,
    input  logic [4:0]    N_in,
    input  logic [15:0]   ram_out_data,
    input  logic [AW-1:0] rd_addr_data,
    output logic          en_rd_data,
    output logic [AW-1:0] rd_addr_data_updated,
    output logic          en_wr_S,
    output logic [6:0]    wr_addr_S,
    output logic [15:0]   wr_data_S,
    output logic          en_wr_N,
    output logic [2:0]    wr_addr_N,
    output logic [4:0]    wr_data_N,
    output logic          done_stp,
    output logic [31:0]   status
);

    stp_state_t    state, state_next;
    logic [2:0]    a_q;
    logic [4:0]    n_q;
    logic [3:0]    idx;
    logic          last_coeff;
    logic          bad_degree;
    logic [AW-1:0] ptr_next;

    assign last_coeff = ({1'b0, idx} == n_q);
    assign bad_degree = (n_q > 5'(max_degree));

    // Buffer pointer advance; explicit wrap so non-power-of-two depths work.
    assign ptr_next = (rd_addr_data_updated == AW'(buffer_size - 1)) ? '0
                    : rd_addr_data_updated + AW'(1);

    // Slot base plus coefficient index; max 7*11+10 = 87 fits in 7 bits.
    assign wr_addr_S = 7'({4'b0, a_q} * 7'(slot_size)) + {3'b0, idx};

    // Buffer read data lands in WR_COEFF and goes straight to the S RAM.
    assign wr_data_S = ram_out_data;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic and Moore output decode.
    always_comb begin
        state_next = state;
        en_rd_data = 1'b0;
        en_wr_S    = 1'b0;
        en_wr_N    = 1'b0;
        wr_addr_N  = a_q;
        wr_data_N  = n_q;
        done_stp   = 1'b0;
        case (state)
            IDLE: begin
                if (start_stp) state_next = START;
            end
            START: begin
                // Invalidate the target slot before touching its coefficients;
                // A_q is not loaded yet, so the address comes from the input.
                en_wr_N    = 1'b1;
                wr_addr_N  = A;
                wr_data_N  = N_INVALID;
                state_next = CHECK_N;
            end
            CHECK_N: begin
                state_next = bad_degree ? ERROR : RD_COEFF;
            end
            RD_COEFF: begin
                en_rd_data = 1'b1;
                state_next = WR_COEFF;
            end
            WR_COEFF: begin
                en_wr_S    = 1'b1;
                state_next = last_coeff ? WR_N : RD_COEFF;
            end
            WR_N: begin
                // Commit: the real degree replaces the invalid marker.
                en_wr_N    = 1'b1;
                wr_addr_N  = a_q;
                wr_data_N  = n_q;
                state_next = END;
            end
            ERROR: begin
                state_next = END;
            end
            END: begin
                done_stp   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request latches, coefficient index, buffer pointer and status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q                  <= '0;
            n_q                  <= '0;
            idx                  <= '0;
            rd_addr_data_updated <= '0;
            status               <= STATUS_NONE;
        end else begin
            case (state)
                START: begin
                    a_q                  <= A;
                    n_q                  <= N_in;
                    idx                  <= '0;
                    rd_addr_data_updated <= rd_addr_data;
                    status               <= STATUS_NONE;
                end
                WR_COEFF: begin
                    rd_addr_data_updated <= ptr_next;
                    // Hold idx on the last coefficient so it never passes max_degree.
                    if (!last_coeff) idx <= idx + 4'd1;
                end
                WR_N:    status <= STATUS_OK;
                ERROR:   status <= STATUS_BAD_N;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stp_fsm.sv
// Testbench for stp_fsm: a schedule model predicts, per cycle, every enable,
// address, data, status and pointer value; a negedge process compares the DUT
// against it, and directed stores are followed by hand-computed literal checks.
module tb_stp_fsm;

    localparam int SZ   = 1024;
    localparam int MAXC = 512;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_stp;
    logic [2:0]  A;
    logic [4:0]  N_in;
    logic [15:0] ram_out_data;
    logic [9:0]  rd_addr_data;
    logic        en_rd_data;
    logic [9:0]  rd_addr_data_updated;
    logic        en_wr_S;
    logic [6:0]  wr_addr_S;
    logic [15:0] wr_data_S;
    logic        en_wr_N;
    logic [2:0]  wr_addr_N;
    logic [4:0]  wr_data_N;
    logic        done_stp;
    logic [31:0] status;

    stp_fsm dut (
        .clk                  (clk),
        .rst                  (rst),
        .start_stp            (start_stp),
        .A                    (A),
        .N_in                 (N_in),
        .ram_out_data         (ram_out_data),
        .rd_addr_data         (rd_addr_data),
        .en_rd_data           (en_rd_data),
        .rd_addr_data_updated (rd_addr_data_updated),
        .en_wr_S              (en_wr_S),
        .wr_addr_S            (wr_addr_S),
        .wr_data_S            (wr_data_S),
        .en_wr_N              (en_wr_N),
        .wr_addr_N            (wr_addr_N),
        .wr_data_N            (wr_data_N),
        .done_stp             (done_stp),
        .status               (status)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Input data buffer: read data appears the cycle after en_rd_data.
    logic [15:0] buffer [0:SZ-1];
    always @(posedge clk) if (en_rd_data === 1'b1) ram_out_data <= buffer[rd_addr_data_updated];

    // Expected outputs per absolute cycle.
    bit          x_rd      [MAXC];
    int          x_rd_addr [MAXC];
    bit          x_ws      [MAXC];
    int          x_ws_addr [MAXC];
    logic [15:0] x_ws_data [MAXC];
    bit          x_wn      [MAXC];
    int          x_wn_addr [MAXC];
    int          x_wn_data [MAXC];
    bit          x_done    [MAXC];
    logic [31:0] x_status  [MAXC];
    int          x_ptr     [MAXC];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Everything from cycle r on looks like the block just left reset.
    task automatic apply_reset(input int r);
        for (int c = r; c < MAXC; c++) begin
            x_rd[c] = 0; x_ws[c] = 0; x_wn[c] = 0; x_done[c] = 0;
            x_status[c] = 32'hFFFF_FFFF; x_ptr[c] = 0;
        end
    endtask

    // Schedule of a store whose start_stp is sampled at the edge ending cycle s:
    // cycle 1 invalidates the slot, coefficient k is read in 3+2k and written
    // in 4+2k, commit in 2N+5, done in 2N+6; illegal degrees finish in cycle 4.
    task automatic plan(input int s, input int a, input int n, input int p);
        x_wn[s+1] = 1; x_wn_addr[s+1] = a; x_wn_data[s+1] = 31;
        for (int c = s + 2; c < MAXC; c++) begin
            x_status[c] = 32'hFFFF_FFFF;
            x_ptr[c]    = p;
        end
        if (n > 10) begin
            x_done[s+4] = 1;
            for (int c = s + 4; c < MAXC; c++) x_status[c] = 32'd2;
        end else begin
            for (int k = 0; k <= n; k++) begin
                int q;
                q = (p + k) % SZ;
                x_rd[s+3+2*k] = 1; x_rd_addr[s+3+2*k] = q;
                x_ws[s+4+2*k] = 1; x_ws_addr[s+4+2*k] = a * 11 + k; x_ws_data[s+4+2*k] = buffer[q];
                for (int c = s + 5 + 2*k; c < MAXC; c++) x_ptr[c] = (p + k + 1) % SZ;
            end
            x_wn[s+2*n+5] = 1; x_wn_addr[s+2*n+5] = a; x_wn_data[s+2*n+5] = n;
            x_done[s+2*n+6] = 1;
            for (int c = s + 2*n + 6; c < MAXC; c++) x_status[c] = 32'd0;
        end
    endtask

    // Shadow RAMs and event counters built from the DUT's write ports.
    logic [15:0] sram [0:127];
    logic [4:0]  nram [0:7];
    int last_done = -1;
    int s_wr_cnt  = 0;
    int rd_cnt    = 0;

    // Per-cycle compare against the schedule model.
    always @(negedge clk) begin
        if (cyc < MAXC) begin
            check("en_rd_data", en_rd_data, x_rd[cyc]);
            check("en_wr_S", en_wr_S, x_ws[cyc]);
            check("en_wr_N", en_wr_N, x_wn[cyc]);
            check("done_stp", done_stp, x_done[cyc]);
            check("status", status, x_status[cyc]);
            check("rd_addr_data_updated", rd_addr_data_updated, x_ptr[cyc]);
            if (x_rd[cyc]) check("rd_addr", rd_addr_data_updated, x_rd_addr[cyc]);
            if (x_ws[cyc]) begin
                check("wr_addr_S", wr_addr_S, x_ws_addr[cyc]);
                check("wr_data_S", wr_data_S, x_ws_data[cyc]);
            end
            if (x_wn[cyc]) begin
                check("wr_addr_N", wr_addr_N, x_wn_addr[cyc]);
                check("wr_data_N", wr_data_N, x_wn_data[cyc]);
            end
        end
        if (en_wr_S === 1'b1) begin sram[wr_addr_S] = wr_data_S; s_wr_cnt++; end
        if (en_wr_N === 1'b1) nram[wr_addr_N] = wr_data_N;
        if (en_rd_data === 1'b1) rd_cnt++;
        if (done_stp === 1'b1) last_done = cyc;
    end

    // Launch one store; returns at the negedge of cycle 2 of the store.
    task automatic do_store(input int a, input int n, input int p, output int s);
        @(negedge clk);
        A = 3'(a); N_in = 5'(n); rd_addr_data = 10'(p); start_stp = 1'b1;
        s = cyc;
        plan(s, a, n, p);
        last_done = -1; s_wr_cnt = 0; rd_cnt = 0;
        @(negedge clk);
        start_stp = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int s, s1, s2;
        rst = 1'b1; start_stp = 1'b0; A = '0; N_in = '0; rd_addr_data = '0;
        ram_out_data = '0;
        for (int i = 0; i < SZ; i++) buffer[i] = 16'(16'h1000 + i * 7);
        for (int i = 0; i < 128; i++) sram[i] = '0;
        for (int i = 0; i < 8; i++) nram[i] = '0;
        apply_reset(0);

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset status", status, 32'hFFFF_FFFF);
        check("reset ptr", rd_addr_data_updated, 0);
        check("reset done", done_stp, 0);
        rst = 1'b0;
        @(negedge clk);

        // Legal store A=3, N=2 from pointer 5.
        buffer[5] = 16'h0004; buffer[6] = 16'h0003; buffer[7] = 16'h0002;
        do_store(3, 2, 5, s);
        repeat (9) @(negedge clk);
        check("t1 done cycle", last_done - s, 10);
        check("t1 S[33]", sram[33], 16'h0004);
        check("t1 S[34]", sram[34], 16'h0003);
        check("t1 S[35]", sram[35], 16'h0002);
        check("t1 N[3]", nram[3], 2);
        check("t1 status", status, 0);
        check("t1 ptr", rd_addr_data_updated, 8);

        // Illegal degree: only the invalidation write happens.
        do_store(1, 12, 8, s);
        repeat (4) @(negedge clk);
        check("t2 done cycle", last_done - s, 4);
        check("t2 status", status, 2);
        check("t2 N[1]", nram[1], 31);
        check("t2 S writes", s_wr_cnt, 0);
        check("t2 reads", rd_cnt, 0);
        check("t2 ptr", rd_addr_data_updated, 8);

        // Degree zero into the last slot.
        buffer[0] = 16'hBEEF;
        do_store(7, 0, 0, s);
        repeat (6) @(negedge clk);
        check("t3 done cycle", last_done - s, 6);
        check("t3 S[77]", sram[77], 16'hBEEF);
        check("t3 N[7]", nram[7], 0);
        check("t3 S writes", s_wr_cnt, 1);

        // Pointer wrap across the end of the buffer.
        buffer[1022] = 16'hA1A1; buffer[1023] = 16'hA2A2; buffer[1] = 16'hA4A4;
        do_store(0, 3, 1022, s);
        repeat (12) @(negedge clk);
        check("t4 done cycle", last_done - s, 12);
        check("t4 ptr", rd_addr_data_updated, 2);
        check("t4 S[0]", sram[0], 16'hA1A1);
        check("t4 S[1]", sram[1], 16'hA2A2);
        check("t4 S[2]", sram[2], 16'hBEEF);
        check("t4 S[3]", sram[3], 16'hA4A4);
        check("t4 reads", rd_cnt, 4);

        // Reset in cycle 5 of an N=10 store to slot 2.
        do_store(2, 10, 100, s);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        apply_reset(s + 5);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("t5 N[2]", nram[2], 31);
        check("t5 S[22]", sram[22], buffer[100]);
        check("t5 S[23]", sram[23], 0);
        check("t5 S writes", s_wr_cnt, 1);
        do_store(6, 1, 50, s);
        repeat (7) @(negedge clk);
        check("t5b done cycle", last_done - s, 8);
        check("t5b N[6]", nram[6], 1);
        check("t5b ptr", rd_addr_data_updated, 52);

        // start_stp held high: the second store starts only after END -> IDLE.
        @(negedge clk);
        A = 3'd4; N_in = 5'd1; rd_addr_data = 10'd20; start_stp = 1'b1;
        s1 = cyc;
        plan(s1, 4, 1, 20);
        repeat (2) @(negedge clk);
        A = 3'd5; N_in = 5'd1; rd_addr_data = 10'd30;
        s2 = s1 + 9;
        plan(s2, 5, 1, 30);
        repeat (8) @(negedge clk);
        start_stp = 1'b0;
        repeat (9) @(negedge clk);
        check("t6 done cycle", last_done - s2, 8);
        check("t6 N[4]", nram[4], 1);
        check("t6 N[5]", nram[5], 1);
        check("t6 S[44]", sram[44], buffer[20]);
        check("t6 S[45]", sram[45], buffer[21]);
        check("t6 S[55]", sram[55], buffer[30]);
        check("t6 S[56]", sram[56], buffer[31]);
        check("t6 ptr", rd_addr_data_updated, 32);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stp_fsm.md
Name: stp_fsm

Overview:
- Store-polynomial writer. Loads one polynomial's coefficients from the shared input data buffer into the coefficient RAM (S RAM) and its degree into the degree RAM (N RAM).
- It is the write-side counterpart of the evaluate (EVP) FSM.
- EVP reads S at address A*11+i and N at address A. It treats N==5'b11111 as an invalid slot.
- This block owns the slot-invalidation and commit protocol that EVP relies on.

Parameters:
- buffer_size, 1024, depth of the input data buffer; the read pointer width is log2(buffer_size).
- slot_size, 11, S RAM words per polynomial slot.
- max_degree, 10, largest legal N; must be slot_size-1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_stp  in  1  request to store a polynomial; sampled only in IDLE.
- A  in  3  target slot index 0..7; sampled in START.
- N_in  in  5  polynomial degree; N_in+1 coefficients follow in the buffer; sampled in START.
- ram_out_data  in  16  data-buffer read data; valid the cycle after en_rd_data.
- rd_addr_data  in  log2(buffer_size)  current buffer read pointer from the scheduler; loaded in START.
- en_rd_data  out  1  data-buffer read enable.
- rd_addr_data_updated  out  log2(buffer_size)  advanced read pointer, returned to the scheduler.
- en_wr_S  out  1  S RAM write enable.
- wr_addr_S  out  7  S RAM write address, equal to A_q*11+idx.
- wr_data_S  out  16  S RAM write data, passed through from ram_out_data.
- en_wr_N  out  1  N RAM write enable.
- wr_addr_N  out  3  N RAM write address, equal to A_q.
- wr_data_N  out  5  N RAM write data.
- done_stp  out  1  one-cycle completion pulse.
- status  out  32  0 = stored OK; 2 = illegal degree; all-ones = no result yet.

Behaviour:
- Reset (asynchronous, active-high): state IDLE; rd_addr_data_updated=0; idx=0; A_q=0; N_q=0; status=32'hFFFFFFFF; done_stp=0; all enables 0.
- Outputs are Moore-decoded from registered state and counters. wr_data_S is a combinational pass-through of ram_out_data. Write addresses and data are don't-care when their enable is 0.
- States:
  - IDLE: if start_stp, go to START; else stay. status holds its last value. start_stp in any other state is ignored.
  - START: latch A_q=A, N_q=N_in; rd_addr_data_updated<=rd_addr_data; idx<=0; status<=all-ones. Drive en_wr_N=1, wr_addr_N=A, wr_data_N=5'b11111 to invalidate the slot before any S write. Go to CHECK_N.
  - CHECK_N: if N_q>max_degree (11..31, including 31), go to ERROR; else go to RD_COEFF.
  - RD_COEFF: en_rd_data=1 at rd_addr_data_updated. Go to WR_COEFF.
  - WR_COEFF: en_wr_S=1, wr_addr_S=A_q*11+idx, wr_data_S=ram_out_data. rd_addr_data_updated<=+1, wrapping modulo buffer_size. idx<=idx+1. If idx==N_q go to WR_N; else go to RD_COEFF.
  - WR_N: en_wr_N=1, wr_addr_N=A_q, wr_data_N=N_q, which commits the slot. status<=0. Go to END.
  - ERROR: status<=2. No S writes and no buffer reads; rd_addr_data_updated is unchanged. The slot stays invalid (31). Go to END.
  - END: done_stp=1. Go to IDLE.
- Latency, counted from the edge that samples start_stp in IDLE:
  - Legal N: done_stp is high in cycle 2N+6.
  - Illegal N: done_stp is high in cycle 4.
  - Exactly N+1 S writes occur, then exactly one committing N write.
- Addresses: wr_addr_S maximum is 7*11+10=87, which fits in 7 bits. idx is 4 bits and never exceeds 10.
- Pointer wrap: buffer_size-1 followed by +1 gives 0.
- Reset mid-operation returns the block to IDLE immediately. The slot keeps N=31, because the invalidation was written in START, so EVP rejects the half-written slot.
- N=0: one RD/WR pair, then WR_N writes 0.

Decomposition:
- Shared package (also used by EVP):
  - state encoding localparams;
  - STATUS_OK=0, STATUS_BAD_N=2, STATUS_NONE=32'hFFFFFFFF;
  - SLOT_SIZE=11, N_INVALID=5'b11111;
  - the log2 function.
- No sub-module. The A*11+idx address generator is one expression kept inline.

Test Plan:
- Store A=3, N_in=2, rd_addr_data=5, buffer[5..7]=16'h0004,16'h0003,16'h0002 -> N write (3,31) in cycle 1; S writes (33,4),(34,3),(35,2); N write (3,2); done_stp in cycle 10; status=0; rd_addr_data_updated=8.
- N_in=12, A=1 -> N write (1,31) only; no S write; no en_rd_data; done_stp in cycle 4; status=2; rd_addr_data_updated unchanged.
- N_in=0, A=7, buffer[0]=16'hBEEF -> S write (77,16'hBEEF); N write (7,0); done_stp in cycle 6.
- rd_addr_data=1022, N_in=3 -> reads at 1022,1023,0,1; rd_addr_data_updated=2.
- Assert rst in cycle 5 of an N_in=10 store to A=2 -> outputs return to reset values at once; the last N write seen was (2,31); later start_stp works normally.
- start_stp held high through a whole store -> second store begins only after END→IDLE; no corruption of the first slot.
